// File: rtl/encoder_ram_arbiter.sv
// encoder_ram_arbiter: shares one single-port RAM between the encoder core (ENC)
// and the host load/unload port (HOST). Round-robin per cycle, with an optional
// ENC lock for read-modify-write bursts that is bounded by a watchdog.
//
// Handshake: req acts as valid and gnt as ready. An access completes in the cycle
// where req & gnt are both high. The requester holds we/addr/wdata stable until
// then. Dropping req before gnt is legal (no cancel). Grants are combinational in
// the request cycle. A granted read returns rvalid/rdata exactly one cycle later
// on the port that issued it.
module encoder_ram_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enc_req,
  input  logic                  enc_we,
  input  logic                  enc_lock,
  input  logic [ADDR_WIDTH-1:0] enc_addr,
  input  logic [DATA_WIDTH-1:0] enc_wdata,
  output logic                  enc_gnt,
  output logic                  enc_rvalid,
  output logic [DATA_WIDTH-1:0] enc_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  lock_timeout,
  output logic                  arb_state    // 1 while ENC holds the lock
);

  typedef enum logic { IDLE_RR = 1'b0, ENC_LOCKED = 1'b1 } state_t;
  typedef enum logic [1:0] { OWN_NONE = 2'd0, OWN_ENC = 2'd1, OWN_HOST = 2'd2 } owner_t;

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  state_t           state, state_next;
  owner_t           owner;
  logic             last_host, last_host_next;   // 1: HOST won the most recent grant
  logic [CNT_W-1:0] lock_cnt, lock_cnt_next;
  logic             timeout_set;
  logic [DATA_WIDTH-1:0] enc_rdata_q, host_rdata_q;

  assign arb_state = (state == ENC_LOCKED);

  // Arbitration: grants, next state, lock run length and round-robin pointer.
  always_comb begin
    enc_gnt        = 1'b0;
    host_gnt       = 1'b0;
    state_next     = state;
    last_host_next = last_host;
    lock_cnt_next  = lock_cnt;
    timeout_set    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE_RR: begin
          if (enc_req && host_req) begin
            enc_gnt  = last_host;
            host_gnt = !last_host;
          end else begin
            enc_gnt  = enc_req;
            host_gnt = host_req;
          end
          if (enc_gnt) begin
            last_host_next = 1'b0;
            if (enc_lock) begin
              state_next    = ENC_LOCKED;
              lock_cnt_next = CNT_W'(1);
            end
          end
          if (host_gnt) last_host_next = 1'b1;
        end
        ENC_LOCKED: begin
          // HOST is held off even when ENC is idle; any release leaves ENC as last winner.
          enc_gnt        = enc_req;
          last_host_next = 1'b0;
          if (enc_req) begin
            if (enc_lock) begin
              if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
                state_next    = IDLE_RR;
                lock_cnt_next = '0;
                timeout_set   = 1'b1;
              end else begin
                lock_cnt_next = lock_cnt + CNT_W'(1);
              end
            end else begin
              state_next    = IDLE_RR;
              lock_cnt_next = '0;
            end
          end else if (!enc_lock) begin
            state_next    = IDLE_RR;
            lock_cnt_next = '0;
          end
        end
        default: begin
          state_next    = IDLE_RR;
          lock_cnt_next = '0;
        end
      endcase
    end
  end

  // RAM port mux: follows whichever requester is granted, quiet when none is.
  always_comb begin
    ram_cs    = enc_gnt | host_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (enc_gnt) begin
      ram_we    = enc_we;
      ram_addr  = enc_addr;
      ram_wdata = enc_wdata;
    end else if (host_gnt) begin
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end
  end

  // Arbiter state, lock counter, round-robin pointer and sticky watchdog flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE_RR;
      last_host    <= 1'b1;
      lock_cnt     <= '0;
      lock_timeout <= 1'b0;
    end else begin
      state     <= state_next;
      last_host <= last_host_next;
      lock_cnt  <= lock_cnt_next;
      if (timeout_set) lock_timeout <= 1'b1;
    end
  end

  // Owner tag for the read in flight; decides which port sees the returning data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= OWN_NONE;
    end else if (enc_gnt && !enc_we) begin
      owner <= OWN_ENC;
    end else if (host_gnt && !host_we) begin
      owner <= OWN_HOST;
    end else begin
      owner <= OWN_NONE;
    end
  end

  // Hold each port's last returned word so its rdata is stable between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      if (owner == OWN_ENC)  enc_rdata_q  <= ram_rdata;
      if (owner == OWN_HOST) host_rdata_q <= ram_rdata;
    end
  end

  assign enc_rvalid  = (owner == OWN_ENC);
  assign host_rvalid = (owner == OWN_HOST);
  assign enc_rdata   = enc_rvalid  ? ram_rdata : enc_rdata_q;
  assign host_rdata  = host_rvalid ? ram_rdata : host_rdata_q;

endmodule
